// File: rtl/eu_opbuf_mp.sv
// eu_opbuf_mp -- multi-channel, address-tagged operand buffer for the
// execution-unit cache.
//
// The buffer has 2^NUM_IDX_BITS entries. Each entry holds a valid bit, an
// ADDR_W tag and a DATA_W data word. NUM_WR_CH producers write into the
// shared storage, and NUM_RD_CH request ports look entries up by their full
// tag. A hit frees the entry when CONSUME_ON_READ = 1.
//
// Handshake: a request (wr_valid_i / rd_valid_i) is presented for one cycle.
// The matching *_success_o is combinational in that same cycle. A write that
// sees success = 0 has changed nothing, and the producer simply retries.
//
// Ports:
//   clk, reset      rising-edge clock, synchronous active-high reset
//   wr_addr_i       NUM_WR_CH packed write tags
//   wr_data_i       NUM_WR_CH packed write data
//   wr_valid_i      write request per channel
//   wr_success_o    write accepted this cycle (independent of rd_*)
//   rd_addr_i       NUM_RD_CH packed request tags
//   rd_valid_i      request valid per port
//   rd_data_o       hit data per port (0 on miss)
//   rd_success_o    hit per port
//   occupancy_o     registered count of valid entries
//   full_o, empty_o derived from occupancy_o
//
// Optional build macro: EU_OPBUF_WR_BYPASS_EN. When it is defined, a read
// that misses in storage can be satisfied by a same-cycle successful write
// to the same tag. With CONSUME_ON_READ = 1, such a write is then not stored.
module eu_opbuf_mp #(
  parameter int NUM_WR_CH       = 2,
  parameter int NUM_RD_CH       = 2,
  parameter int NUM_IDX_BITS    = 3,
  parameter int ADDR_W          = 8,
  parameter int DATA_W          = 16,
  parameter bit CONSUME_ON_READ = 1'b1
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic [NUM_WR_CH*ADDR_W-1:0] wr_addr_i,
  input  logic [NUM_WR_CH*DATA_W-1:0] wr_data_i,
  input  logic [NUM_WR_CH-1:0]        wr_valid_i,
  output logic [NUM_WR_CH-1:0]        wr_success_o,
  input  logic [NUM_RD_CH*ADDR_W-1:0] rd_addr_i,
  input  logic [NUM_RD_CH-1:0]        rd_valid_i,
  output logic [NUM_RD_CH*DATA_W-1:0] rd_data_o,
  output logic [NUM_RD_CH-1:0]        rd_success_o,
  output logic [NUM_IDX_BITS:0]       occupancy_o,
  output logic                        full_o,
  output logic                        empty_o
);

  localparam int DEPTH = 1 << NUM_IDX_BITS;
  localparam int CW    = NUM_IDX_BITS + 1;

  logic [DEPTH-1:0]  valid_q;
  logic [ADDR_W-1:0] tag_q  [DEPTH];
  logic [DATA_W-1:0] data_q [DEPTH];
  logic [CW-1:0]     occ_q;

  // Write decode: each channel either overwrites an existing entry, or
  // allocates a free one, or fails. It only looks at registered state, so no
  // read-to-write path exists.
  logic [NUM_WR_CH-1:0]    wr_ow;
  logic [NUM_WR_CH-1:0]    wr_alloc;
  logic [NUM_IDX_BITS-1:0] wr_idx [NUM_WR_CH];

  always_comb begin
    logic [DEPTH-1:0]        claimed;
    logic                    hit;
    logic                    dup;
    logic                    found;
    logic [NUM_IDX_BITS-1:0] idx;
    logic [NUM_IDX_BITS-1:0] free_idx;
    claimed      = '0;
    wr_ow        = '0;
    wr_alloc     = '0;
    wr_success_o = '0;
    for (int c = 0; c < NUM_WR_CH; c++) wr_idx[c] = '0;
    for (int c = 0; c < NUM_WR_CH; c++) begin
      hit      = 1'b0;
      dup      = 1'b0;
      found    = 1'b0;
      idx      = '0;
      free_idx = '0;
      // Descending scans leave the lowest matching index in place.
      for (int e = DEPTH - 1; e >= 0; e--) begin
        if (valid_q[e] && tag_q[e] == wr_addr_i[c*ADDR_W +: ADDR_W]) begin
          hit = 1'b1;
          idx = NUM_IDX_BITS'(e);
        end
        if (!valid_q[e] && !claimed[e]) begin
          found    = 1'b1;
          free_idx = NUM_IDX_BITS'(e);
        end
      end
      // If a lower channel already allocates this new tag, this channel must
      // not create a second copy.
      for (int k = 0; k < NUM_WR_CH; k++) begin
        if (k < c && wr_alloc[k] &&
            wr_addr_i[k*ADDR_W +: ADDR_W] == wr_addr_i[c*ADDR_W +: ADDR_W])
          dup = 1'b1;
      end
      if (wr_valid_i[c]) begin
        if (hit) begin
          wr_ow[c]        = 1'b1;
          wr_success_o[c] = 1'b1;
          wr_idx[c]       = idx;
        end else if (!dup && found) begin
          wr_alloc[c]       = 1'b1;
          wr_success_o[c]   = 1'b1;
          wr_idx[c]         = free_idx;
          claimed[free_idx] = 1'b1;
        end
      end
    end
  end

  // Read lookup against registered entries. The optional bypass uses
  // same-cycle successful writes.
  logic [DEPTH-1:0]     rd_hit_mask;
  logic [NUM_WR_CH-1:0] wr_byp;

  always_comb begin
    logic                    hit;
    logic [NUM_IDX_BITS-1:0] idx;
`ifdef EU_OPBUF_WR_BYPASS_EN
    logic                    bhit;
    int                      bch;
`endif
    rd_hit_mask  = '0;
    wr_byp       = '0;
    rd_success_o = '0;
    rd_data_o    = '0;
    for (int p = 0; p < NUM_RD_CH; p++) begin
      hit = 1'b0;
      idx = '0;
      for (int e = DEPTH - 1; e >= 0; e--) begin
        if (valid_q[e] && tag_q[e] == rd_addr_i[p*ADDR_W +: ADDR_W]) begin
          hit = 1'b1;
          idx = NUM_IDX_BITS'(e);
        end
      end
      if (rd_valid_i[p] && hit) begin
        rd_success_o[p]                = 1'b1;
        rd_data_o[p*DATA_W +: DATA_W] = data_q[idx];
        rd_hit_mask[idx]               = 1'b1;
      end
`ifdef EU_OPBUF_WR_BYPASS_EN
      else if (rd_valid_i[p]) begin
        bhit = 1'b0;
        bch  = 0;
        for (int c = NUM_WR_CH - 1; c >= 0; c--) begin
          if (wr_success_o[c] &&
              wr_addr_i[c*ADDR_W +: ADDR_W] == rd_addr_i[p*ADDR_W +: ADDR_W]) begin
            bhit = 1'b1;
            bch  = c;
          end
        end
        if (bhit) begin
          rd_success_o[p]                = 1'b1;
          rd_data_o[p*DATA_W +: DATA_W] = wr_data_i[bch*DATA_W +: DATA_W];
          // The read consumes the data in flight, so the write is not stored.
          if (CONSUME_ON_READ) wr_byp[bch] = 1'b1;
        end
      end
`endif
    end
  end

  // Next-state valid bits and occupancy. An overwriting write keeps its entry
  // alive even when a read consumes that entry in the same cycle.
  logic [DEPTH-1:0] consume_mask;
  logic [DEPTH-1:0] ow_mask;
  logic [DEPTH-1:0] alloc_mask;
  logic [DEPTH-1:0] valid_nxt;
  int               alloc_cnt;
  int               cons_cnt;
  int               occ_sum;

  always_comb begin
    ow_mask    = '0;
    alloc_mask = '0;
    for (int c = 0; c < NUM_WR_CH; c++) begin
      if (wr_ow[c])                 ow_mask[wr_idx[c]]    = 1'b1;
      if (wr_alloc[c] && !wr_byp[c]) alloc_mask[wr_idx[c]] = 1'b1;
    end
    consume_mask = CONSUME_ON_READ ? rd_hit_mask : '0;
    valid_nxt    = (valid_q & ~consume_mask) | ow_mask | alloc_mask;
    alloc_cnt    = 0;
    cons_cnt     = 0;
    for (int e = 0; e < DEPTH; e++) begin
      alloc_cnt = alloc_cnt + int'(alloc_mask[e]);
      cons_cnt  = cons_cnt + int'(consume_mask[e] & ~ow_mask[e]);
    end
    occ_sum = int'(occ_q) + alloc_cnt - cons_cnt;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      valid_q <= '0;
      occ_q   <= '0;
    end else begin
      valid_q <= valid_nxt;
      occ_q   <= CW'(occ_sum);
      assert (occ_sum >= 0 && occ_sum <= DEPTH);
    end
  end

  // Tag and data storage is not reset. Valid bits alone decide visibility.
  always_ff @(posedge clk) begin
    if (!reset) begin
      for (int c = 0; c < NUM_WR_CH; c++) begin
        if (wr_ow[c] || (wr_alloc[c] && !wr_byp[c])) begin
          tag_q[wr_idx[c]]  <= wr_addr_i[c*ADDR_W +: ADDR_W];
          data_q[wr_idx[c]] <= wr_data_i[c*DATA_W +: DATA_W];
        end
      end
    end
  end

  assign occupancy_o = occ_q;
  assign full_o      = (occ_q == CW'(DEPTH));
  assign empty_o     = (occ_q == '0);

endmodule

// File: tb/tb_eu_opbuf_mp.sv
// Testbench for eu_opbuf_mp with the default parameters (2 write channels,
// 2 read ports, depth 8, 8-bit tags, 16-bit data, consume on read).
// The first part runs directed vectors from a table. The second part runs
// random traffic against a tag->data map model.
module tb_eu_opbuf_mp;

  localparam int DEPTH = 8;

  logic        clk = 1'b0;
  logic        reset;
  logic [15:0] wr_addr;
  logic [31:0] wr_data;
  logic [1:0]  wr_valid;
  logic [1:0]  wr_success;
  logic [15:0] rd_addr;
  logic [1:0]  rd_valid;
  logic [31:0] rd_data;
  logic [1:0]  rd_success;
  logic [3:0]  occupancy;
  logic        full;
  logic        empty;

  int tests = 0;
  int fails = 0;

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  eu_opbuf_mp dut (
    .clk          (clk),
    .reset        (reset),
    .wr_addr_i    (wr_addr),
    .wr_data_i    (wr_data),
    .wr_valid_i   (wr_valid),
    .wr_success_o (wr_success),
    .rd_addr_i    (rd_addr),
    .rd_valid_i   (rd_valid),
    .rd_data_o    (rd_data),
    .rd_success_o (rd_success),
    .occupancy_o  (occupancy),
    .full_o       (full),
    .empty_o      (empty)
  );

  // ---------------- driver tasks ----------------
  task automatic drive(input logic rst, input logic [1:0] wv,
                       input logic [7:0] wa0, input logic [15:0] wd0,
                       input logic [7:0] wa1, input logic [15:0] wd1,
                       input logic [1:0] rv, input logic [7:0] ra0,
                       input logic [7:0] ra1);
    reset    = rst;
    wr_valid = wv;
    wr_addr  = {wa1, wa0};
    wr_data  = {wd1, wd0};
    rd_valid = rv;
    rd_addr  = {ra1, ra0};
  endtask

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic check_all(input string tag, input logic [1:0] ews,
                           input logic [1:0] ers, input logic [15:0] erd0,
                           input logic [15:0] erd1, input logic [3:0] eocc);
    check({tag, " wr_success"}, 32'(wr_success), 32'(ews));
    check({tag, " rd_success"}, 32'(rd_success), 32'(ers));
    check({tag, " rd_data0"}, 32'(rd_data[15:0]), 32'(erd0));
    check({tag, " rd_data1"}, 32'(rd_data[31:16]), 32'(erd1));
    check({tag, " occupancy"}, 32'(occupancy), 32'(eocc));
    check({tag, " full"}, 32'(full), 32'(eocc == 4'(DEPTH)));
    check({tag, " empty"}, 32'(empty), 32'(eocc == 4'd0));
  endtask

  // ---------------- directed vector table ----------------
  typedef struct {
    logic        rst;
    logic [1:0]  wv;
    logic [7:0]  wa0;
    logic [15:0] wd0;
    logic [7:0]  wa1;
    logic [15:0] wd1;
    logic [1:0]  rv;
    logic [7:0]  ra0;
    logic [7:0]  ra1;
    logic [1:0]  ews;
    logic [1:0]  ers;
    logic [15:0] erd0;
    logic [15:0] erd1;
    logic [3:0]  eocc;
    logic        chk;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(logic rst, logic [1:0] wv, logic [7:0] wa0,
                              logic [15:0] wd0, logic [7:0] wa1,
                              logic [15:0] wd1, logic [1:0] rv,
                              logic [7:0] ra0, logic [7:0] ra1,
                              logic [1:0] ews, logic [1:0] ers,
                              logic [15:0] erd0, logic [15:0] erd1,
                              logic [3:0] eocc, logic chk);
    vec_t v;
    v.rst = rst; v.wv = wv; v.wa0 = wa0; v.wd0 = wd0; v.wa1 = wa1;
    v.wd1 = wd1; v.rv = rv; v.ra0 = ra0; v.ra1 = ra1; v.ews = ews;
    v.ers = ers; v.erd0 = erd0; v.erd1 = erd1; v.eocc = eocc; v.chk = chk;
    return v;
  endfunction

  // ---------------- scoreboard ----------------
  // Packed expected record: {ws[1:0], rs[1:0], rd1, rd0, occ[3:0]}.
  logic [39:0] exp_q[$];
  logic [15:0] m[logic [7:0]];
  logic [15:0] nm[logic [7:0]];

  initial begin
    logic        rst;
    logic [1:0]  wv;
    logic [1:0]  rv;
    logic [7:0]  wa[2];
    logic [15:0] wd[2];
    logic [7:0]  ra[2];
    logic [15:0] erd[2];
    logic [1:0]  ews;
    logic [1:0]  ers;
    logic [1:0]  shit;
    logic [1:0]  byp;
    logic [7:0]  newq[$];
    logic [39:0] e;
    int          free;
    bit          seen;

    drive(1'b1, 2'b00, 8'h0, 16'h0, 8'h0, 16'h0, 2'b00, 8'h0, 8'h0);

    // rst wv wa0 wd0 wa1 wd1 rv ra0 ra1 | ews ers erd0 erd1 eocc chk
    vecs.push_back(mk(1, 2'b00, 8'h00, 16'h0000, 8'h00, 16'h0000, 2'b00, 8'h00, 8'h00, 2'b00, 2'b00, 16'h0000, 16'h0000, 4'd0, 0));
    vecs.push_back(mk(1, 2'b00, 8'h00, 16'h0000, 8'h00, 16'h0000, 2'b00, 8'h00, 8'h00, 2'b00, 2'b00, 16'h0000, 16'h0000, 4'd0, 0));
    vecs.push_back(mk(0, 2'b00, 8'h00, 16'h0000, 8'h00, 16'h0000, 2'b11, 8'h00, 8'h12, 2'b00, 2'b00, 16'h0000, 16'h0000, 4'd0, 1));
    vecs.push_back(mk(0, 2'b01, 8'h12, 16'hBEEF, 8'h00, 16'h0000, 2'b00, 8'h00, 8'h00, 2'b01, 2'b00, 16'h0000, 16'h0000, 4'd0, 1));
    vecs.push_back(mk(0, 2'b00, 8'h00, 16'h0000, 8'h00, 16'h0000, 2'b10, 8'h00, 8'h12, 2'b00, 2'b10, 16'h0000, 16'hBEEF, 4'd1, 1));
    vecs.push_back(mk(0, 2'b00, 8'h00, 16'h0000, 8'h00, 16'h0000, 2'b00, 8'h00, 8'h00, 2'b00, 2'b00, 16'h0000, 16'h0000, 4'd0, 1));
    vecs.push_back(mk(0, 2'b11, 8'h33, 16'h0001, 8'h33, 16'h0002, 2'b00, 8'h00, 8'h00, 2'b01, 2'b00, 16'h0000, 16'h0000, 4'd0, 1));
    vecs.push_back(mk(0, 2'b00, 8'h00, 16'h0000, 8'h00, 16'h0000, 2'b01, 8'h33, 8'h00, 2'b00, 2'b01, 16'h0001, 16'h0000, 4'd1, 1));
    vecs.push_back(mk(0, 2'b01, 8'h44, 16'hA5A5, 8'h00, 16'h0000, 2'b00, 8'h00, 8'h00, 2'b01, 2'b00, 16'h0000, 16'h0000, 4'd0, 1));
    vecs.push_back(mk(0, 2'b00, 8'h00, 16'h0000, 8'h00, 16'h0000, 2'b11, 8'h44, 8'h44, 2'b00, 2'b11, 16'hA5A5, 16'hA5A5, 4'd1, 1));
    vecs.push_back(mk(0, 2'b00, 8'h00, 16'h0000, 8'h00, 16'h0000, 2'b00, 8'h00, 8'h00, 2'b00, 2'b00, 16'h0000, 16'h0000, 4'd0, 1));
`ifdef EU_OPBUF_WR_BYPASS_EN
    vecs.push_back(mk(0, 2'b01, 8'h55, 16'h5555, 8'h00, 16'h0000, 2'b01, 8'h55, 8'h00, 2'b01, 2'b01, 16'h5555, 16'h0000, 4'd0, 1));
    vecs.push_back(mk(0, 2'b00, 8'h00, 16'h0000, 8'h00, 16'h0000, 2'b01, 8'h55, 8'h00, 2'b00, 2'b00, 16'h0000, 16'h0000, 4'd0, 1));
`else
    vecs.push_back(mk(0, 2'b01, 8'h55, 16'h5555, 8'h00, 16'h0000, 2'b01, 8'h55, 8'h00, 2'b01, 2'b00, 16'h0000, 16'h0000, 4'd0, 1));
    vecs.push_back(mk(0, 2'b00, 8'h00, 16'h0000, 8'h00, 16'h0000, 2'b01, 8'h55, 8'h00, 2'b00, 2'b01, 16'h5555, 16'h0000, 4'd1, 1));
`endif
    vecs.push_back(mk(0, 2'b00, 8'h00, 16'h0000, 8'h00, 16'h0000, 2'b00, 8'h00, 8'h00, 2'b00, 2'b00, 16'h0000, 16'h0000, 4'd0, 1));
    vecs.push_back(mk(0, 2'b11, 8'h80, 16'h1000, 8'h81, 16'h1001, 2'b00, 8'h00, 8'h00, 2'b11, 2'b00, 16'h0000, 16'h0000, 4'd0, 1));
    vecs.push_back(mk(0, 2'b11, 8'h82, 16'h1002, 8'h83, 16'h1003, 2'b00, 8'h00, 8'h00, 2'b11, 2'b00, 16'h0000, 16'h0000, 4'd2, 1));
    vecs.push_back(mk(0, 2'b11, 8'h84, 16'h1004, 8'h85, 16'h1005, 2'b00, 8'h00, 8'h00, 2'b11, 2'b00, 16'h0000, 16'h0000, 4'd4, 1));
    vecs.push_back(mk(0, 2'b11, 8'h86, 16'h1006, 8'h87, 16'h1007, 2'b00, 8'h00, 8'h00, 2'b11, 2'b00, 16'h0000, 16'h0000, 4'd6, 1));
    // Full: new tags are rejected even while an entry is being consumed.
    vecs.push_back(mk(0, 2'b11, 8'h90, 16'h9090, 8'h91, 16'h9191, 2'b01, 8'h80, 8'h00, 2'b00, 2'b01, 16'h1000, 16'h0000, 4'd8, 1));
    vecs.push_back(mk(0, 2'b01, 8'h90, 16'h9090, 8'h00, 16'h0000, 2'b00, 8'h00, 8'h00, 2'b01, 2'b00, 16'h0000, 16'h0000, 4'd7, 1));
    vecs.push_back(mk(0, 2'b00, 8'h00, 16'h0000, 8'h00, 16'h0000, 2'b00, 8'h00, 8'h00, 2'b00, 2'b00, 16'h0000, 16'h0000, 4'd8, 1));
    // Overwrite races a consume: the read gets old data, the entry survives.
    vecs.push_back(mk(0, 2'b01, 8'h81, 16'hDEAD, 8'h00, 16'h0000, 2'b01, 8'h81, 8'h00, 2'b01, 2'b01, 16'h1001, 16'h0000, 4'd8, 1));
    vecs.push_back(mk(0, 2'b00, 8'h00, 16'h0000, 8'h00, 16'h0000, 2'b10, 8'h00, 8'h81, 2'b00, 2'b10, 16'h0000, 16'hDEAD, 4'd8, 1));
    vecs.push_back(mk(0, 2'b00, 8'h00, 16'h0000, 8'h00, 16'h0000, 2'b01, 8'h99, 8'h82, 2'b00, 2'b00, 16'h0000, 16'h0000, 4'd7, 1));
    // Reset with entries held and a write in flight.
    vecs.push_back(mk(1, 2'b01, 8'hA0, 16'h1234, 8'h00, 16'h0000, 2'b00, 8'h00, 8'h00, 2'b00, 2'b00, 16'h0000, 16'h0000, 4'd0, 0));
    vecs.push_back(mk(0, 2'b00, 8'h00, 16'h0000, 8'h00, 16'h0000, 2'b11, 8'h82, 8'h83, 2'b00, 2'b00, 16'h0000, 16'h0000, 4'd0, 1));
    vecs.push_back(mk(0, 2'b00, 8'h00, 16'h0000, 8'h00, 16'h0000, 2'b01, 8'hA0, 8'h00, 2'b00, 2'b00, 16'h0000, 16'h0000, 4'd0, 1));

    foreach (vecs[i]) begin
      @(negedge clk);
      drive(vecs[i].rst, vecs[i].wv, vecs[i].wa0, vecs[i].wd0, vecs[i].wa1,
            vecs[i].wd1, vecs[i].rv, vecs[i].ra0, vecs[i].ra1);
      #1;
      if (vecs[i].chk)
        check_all($sformatf("vec%0d", i), vecs[i].ews, vecs[i].ers,
                  vecs[i].erd0, vecs[i].erd1, vecs[i].eocc);
    end

    // ---------------- random traffic against the map model ----------------
    @(negedge clk);
    drive(1'b1, 2'b00, 8'h0, 16'h0, 8'h0, 16'h0, 2'b00, 8'h0, 8'h0);
    m.delete();
    for (int cyc = 0; cyc < 800; cyc++) begin
      @(negedge clk);
      rst = ($urandom_range(0, 119) == 0);
      wv  = 2'($urandom_range(0, 3));
      rv  = 2'($urandom_range(0, 3));
      for (int i = 0; i < 2; i++) begin
        wa[i] = 8'hC0 + 8'($urandom_range(0, 11));
        ra[i] = 8'hC0 + 8'($urandom_range(0, 11));
        wd[i] = 16'($urandom);
      end
      drive(rst, wv, wa[0], wd[0], wa[1], wd[1], rv, ra[0], ra[1]);

      // Reads see the stored map. Writes succeed on an existing tag or when
      // room remains, and the first channel claims a new tag.
      ews = '0; ers = '0; shit = '0; byp = '0;
      erd[0] = '0; erd[1] = '0;
      newq.delete();
      for (int p = 0; p < 2; p++) begin
        if (rv[p] && m.exists(ra[p])) begin
          ers[p] = 1'b1; shit[p] = 1'b1; erd[p] = m[ra[p]];
        end
      end
      free = DEPTH - m.num();
      for (int c = 0; c < 2; c++) begin
        seen = 0;
        foreach (newq[j]) if (newq[j] == wa[c]) seen = 1;
        if (wv[c]) begin
          if (m.exists(wa[c])) ews[c] = 1'b1;
          else if (!seen && free > 0) begin
            ews[c] = 1'b1; free--; newq.push_back(wa[c]);
          end
        end
      end
`ifdef EU_OPBUF_WR_BYPASS_EN
      for (int p = 0; p < 2; p++) begin
        if (rv[p] && !ers[p]) begin
          for (int c = 0; c < 2; c++) begin
            if (!ers[p] && ews[c] && wa[c] == ra[p]) begin
              ers[p] = 1'b1; erd[p] = wd[c]; byp[c] = 1'b1;
            end
          end
        end
      end
`endif

      if (!rst) begin
        exp_q.push_back({ews, ers, erd[1], erd[0], 4'(m.num())});
        #1;
        e = exp_q.pop_front();
        check_all($sformatf("rnd%0d", cyc), e[39:38], e[37:36], e[19:4],
                  e[35:20], e[3:0]);
      end

      if (rst) m.delete();
      else begin
        nm = m;
        for (int p = 0; p < 2; p++)
          if (shit[p] && nm.exists(ra[p])) nm.delete(ra[p]);
        for (int c = 0; c < 2; c++)
          if (ews[c] && !byp[c]) nm[wa[c]] = wd[c];
        m = nm;
      end
    end

    @(negedge clk);
    drive(1'b0, 2'b00, 8'h0, 16'h0, 8'h0, 16'h0, 2'b00, 8'h0, 8'h0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
